// File: rtl/jtag_pkg.sv
// Shared command, status and state encodings for the JTAG memory path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package jtag_pkg;

   localparam logic [1:0] CMD_CHECK = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_RSVD  = 2'b11;

   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_OKAY  = 2'b10;
   localparam logic [1:0] ST_ERROR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/jtag_tgl_sync.sv
// Brings a toggle from a foreign clock domain in and turns each edge into a one-cycle pulse.
// Latency: SYNC_STAGES+1 clk edges from toggle change to pulse.
// Backpressure: none; toggles closer than the latency merge or are lost.
module jtag_tgl_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tgl,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchroniser chain, previous-level flop and registered edge pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
         prev_q <= sync_q[SYNC_STAGES-1];
         pulse  <= sync_q[SYNC_STAGES-1] ^ prev_q;
      end
   end

endmodule

// File: rtl/jtag_mem_ctrl.sv
// Decodes TAP requests and runs one READ/WRITE access at a time on a single-port memory.
// Latency: toggle->pulse SYNC_STAGES+1 edges; pulse->OKAY at least 3 edges (ISSUE, WAIT, complete).
// Backpressure: waits on mem_ready for up to TIMEOUT cycles; requests arriving while busy are dropped and flagged in overrun.
module jtag_mem_ctrl
   import jtag_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT     = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              tap_req_tgl,
   input  logic [ADDR_W-1:0] tap_addr,
   input  logic [DATA_W-1:0] tap_wdata,
   input  logic [1:0]        tap_cmd,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        status,
   output logic              ack_tgl,
   output logic              overrun
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   state_t            state, state_nxt;
   logic              req_pulse;
   logic              is_access;
   logic              timed_out;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
   logic [1:0]        cap_cmd;
   logic [CNT_W-1:0]  cnt;

   jtag_tgl_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk   (clk),
      .rst   (sys_rst),
      .tgl   (tap_req_tgl),
      .pulse (req_pulse)
   );

   assign is_access = (tap_cmd == CMD_READ) || (tap_cmd == CMD_WRITE);
   assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state decode; completion and timeout both return to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_pulse && is_access) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (mem_ready || timed_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, memory port drive, completion/timeout handling and status
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_cmd   <= CMD_CHECK;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         status    <= ST_OKAY;
         ack_tgl   <= 1'b0;
         overrun   <= 1'b0;
         cnt       <= '0;
      end else begin
         // Anything that lands while a transaction is in flight is lost
         if (req_pulse && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (req_pulse) begin
                  cap_addr  <= tap_addr;
                  cap_wdata <= tap_wdata;
                  cap_cmd   <= tap_cmd;
                  if (is_access)                status <= ST_BUSY;
                  else if (tap_cmd == CMD_RSVD) status <= ST_ERROR;
               end
            end
            ISSUE: begin
               mem_en    <= 1'b1;
               mem_we    <= (cap_cmd == CMD_WRITE);
               mem_addr  <= cap_addr;
               mem_wdata <= cap_wdata;
               cnt       <= '0;
            end
            WAIT: begin
               if (mem_ready) begin
                  if (cap_cmd == CMD_READ) rdata <= mem_rdata;
                  status  <= ST_OKAY;
                  ack_tgl <= ~ack_tgl;
                  mem_en  <= 1'b0;
               end else if (timed_out) begin
                  status  <= ST_ERROR;
                  ack_tgl <= ~ack_tgl;
                  mem_en  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// Self-checking bench for jtag_mem_ctrl: directed table, multi-cycle corner sequences, randomized requests vs a transaction model.
// Latency: n/a.
// Backpressure: memory stand-in stalls for a programmable number of cycles or forever.
`timescale 1ns/1ps
module tb_jtag_mem_ctrl;
   import jtag_pkg::*;

   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 16;
   localparam int TIMEOUT     = 64;
   localparam int SYNC_STAGES = 2;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        tap_req_tgl;
   logic [7:0]  tap_addr;
   logic [15:0] tap_wdata;
   logic [1:0]  tap_cmd;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_ready = 1'b0;
   logic [15:0] rdata;
   logic [1:0]  status;
   logic        ack_tgl, overrun;

   always #5 clk = ~clk;

   jtag_mem_ctrl #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT), .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk (clk), .sys_rst (sys_rst), .tap_req_tgl (tap_req_tgl), .tap_addr (tap_addr),
      .tap_wdata (tap_wdata), .tap_cmd (tap_cmd), .mem_en (mem_en), .mem_we (mem_we),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
      .mem_ready (mem_ready), .rdata (rdata), .status (status), .ack_tgl (ack_tgl),
      .overrun (overrun)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Memory stand-in: ready after mem_lat cycles of mem_en, or never when stalled
   logic [15:0] ram [256];
   int  mem_lat = 0;
   bit  mem_stall = 1'b0;
   int  en_cnt = 0;
   bit  rst_at_edge = 1'b0;
   always @(posedge clk) begin
      rst_at_edge = sys_rst;
      if (mem_en === 1'b1 && mem_ready && mem_we === 1'b1 && !sys_rst) ram[mem_addr] = mem_wdata;
      #1;
      if (mem_en === 1'b1) begin
         mem_ready = !mem_stall && (en_cnt == mem_lat);
         mem_rdata = ram[mem_addr];
         en_cnt++;
      end else begin
         en_cnt    = 0;
         mem_ready = 1'b0;
         mem_rdata = 16'hDEAD;
      end
   end

   // Observers: ack edges (reset edges excluded), access starts, enable cycles, port stability
   int          ack_edges = 0, en_rise = 0, en_hi = 0, stab_err = 0;
   logic        ack_prev = 1'b0, en_prev = 1'b0;
   logic [24:0] fld_prev = '0;
   logic        last_we = 1'b0;
   logic [7:0]  last_addr = '0;
   logic [15:0] last_wdata = '0;
   always @(posedge clk) begin
      #2;
      if (ack_tgl !== ack_prev && !rst_at_edge) ack_edges++;
      ack_prev = ack_tgl;
      if (mem_en === 1'b1 && en_prev === 1'b0) begin
         en_rise++;
         last_we = mem_we; last_addr = mem_addr; last_wdata = mem_wdata;
      end
      if (mem_en === 1'b1 && en_prev === 1'b1 && {mem_we, mem_addr, mem_wdata} !== fld_prev) stab_err++;
      if (mem_en === 1'b1) en_hi++;
      en_prev  = mem_en;
      fld_prev = {mem_we, mem_addr, mem_wdata};
   end

   // Transaction-level reference model
   logic [15:0] ref_mem [256];
   logic [15:0] m_rdata  = 16'h0000;
   logic [1:0]  m_status = ST_OKAY;
   logic        m_over   = 1'b0;
   int          m_ack = 0, m_rise = 0;

   function automatic logic [15:0] init_val(input int a);
      return (16'(a) * 16'h0101) ^ 16'h5A5A;
   endfunction

   task automatic model_apply(input logic [1:0] cmd, input logic [7:0] a, input logic [15:0] d, input bit stall);
      if (cmd == CMD_READ || cmd == CMD_WRITE) begin
         m_rise++;
         m_ack++;
         if (stall) m_status = ST_ERROR;
         else begin
            m_status = ST_OKAY;
            if (cmd == CMD_READ) m_rdata = ref_mem[a];
            else                 ref_mem[a] = d;
         end
      end else if (cmd == CMD_RSVD) begin
         m_status = ST_ERROR;
      end
   endtask

   task automatic wait_en(input string name);
      int g = 0;
      while (mem_en !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
      check(name, (g < 20), 1);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while (status == ST_BUSY && g < TIMEOUT + 20) begin @(posedge clk); #1; g++; end
      check(name, (g < TIMEOUT + 20), 1);
      @(negedge clk);
   endtask

   task automatic do_req(input logic [1:0] cmd, input logic [7:0] a, input logic [15:0] d,
                         input int lat, input bit stall);
      mem_lat = lat; mem_stall = stall;
      tap_cmd = cmd; tap_addr = a; tap_wdata = d;
      tap_req_tgl = ~tap_req_tgl;
      repeat (SYNC_STAGES + 3) @(posedge clk);
      #1;
      wait_idle("req_done");
      model_apply(cmd, a, d, stall);
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [7:0]  addr;
      logic [15:0] wdata;
      int          lat;
      bit          stall;
      logic [1:0]  e_status;
      logic [15:0] e_rdata;
      int          e_ack;
      int          e_rise;
      bit          e_we;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int          a0, r0, e0;
      logic [1:0]  rc;
      logic [7:0]  ra;
      logic [15:0] rd;
      int          rl;
      bit          rs;

      vecs[0] = '{CMD_WRITE, 8'hC0, 16'hFE81, 3, 1'b0, ST_OKAY,  16'h0000, 1, 1, 1'b1};
      vecs[1] = '{CMD_READ,  8'hC0, 16'h0000, 0, 1'b0, ST_OKAY,  16'hFE81, 1, 1, 1'b0};
      vecs[2] = '{CMD_CHECK, 8'hC0, 16'h0000, 0, 1'b0, ST_OKAY,  16'hFE81, 0, 0, 1'b0};
      vecs[3] = '{CMD_RSVD,  8'h12, 16'h0000, 0, 1'b0, ST_ERROR, 16'hFE81, 0, 0, 1'b0};
      vecs[4] = '{CMD_CHECK, 8'h12, 16'h0000, 0, 1'b0, ST_ERROR, 16'hFE81, 0, 0, 1'b0};
      vecs[5] = '{CMD_READ,  8'h05, 16'h0000, 2, 1'b0, ST_OKAY,  16'h5F5F, 1, 1, 1'b0};
      vecs[6] = '{CMD_WRITE, 8'h05, 16'h1234, 1, 1'b0, ST_OKAY,  16'h5F5F, 1, 1, 1'b1};
      vecs[7] = '{CMD_READ,  8'h05, 16'h0000, 4, 1'b0, ST_OKAY,  16'h1234, 1, 1, 1'b0};
      vecs[8] = '{CMD_READ,  8'hC0, 16'h0000, 0, 1'b1, ST_ERROR, 16'h1234, 1, 1, 1'b0};

      for (int i = 0; i < 256; i++) begin
         ram[i]     = init_val(i);
         ref_mem[i] = init_val(i);
      end

      // Power-on reset
      sys_rst = 1'b1; tap_req_tgl = 1'b0; tap_addr = '0; tap_wdata = '0; tap_cmd = CMD_CHECK;
      repeat (3) @(posedge clk);
      #1 sys_rst = 1'b0;
      check("rst_status",  status,  ST_OKAY);
      check("rst_rdata",   rdata,   16'h0000);
      check("rst_mem_en",  mem_en,  1'b0);
      check("rst_ack_tgl", ack_tgl, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      @(negedge clk);
      check("rst_ack_edges", ack_edges, 0);

      // Minimum-latency WRITE, edge by edge
      mem_lat = 0; mem_stall = 1'b0;
      tap_cmd = CMD_WRITE; tap_addr = 8'h3C; tap_wdata = 16'hA5C3;
      tap_req_tgl = ~tap_req_tgl;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1 check("lat_not_yet_busy", status, ST_OKAY);
      @(posedge clk); #1;
      check("lat_busy",   status, ST_BUSY);
      check("lat_en_lo",  mem_en, 1'b0);
      @(posedge clk); #1;
      check("lat_en_hi",  mem_en, 1'b1);
      check("lat_fields", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h3C, 16'hA5C3});
      check("lat_still_busy", status, ST_BUSY);
      @(posedge clk); #1;
      check("lat_okay",   status, ST_OKAY);
      check("lat_en_drop", mem_en, 1'b0);
      @(negedge clk);
      model_apply(CMD_WRITE, 8'h3C, 16'hA5C3, 1'b0);
      check("lat_ack", ack_edges, m_ack);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         a0 = ack_edges; r0 = en_rise;
         do_req(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].stall);
         check($sformatf("vec%0d_status", i), status, vecs[i].e_status);
         check($sformatf("vec%0d_rdata", i),  rdata,  vecs[i].e_rdata);
         check($sformatf("vec%0d_ack", i),    ack_edges - a0, vecs[i].e_ack);
         check($sformatf("vec%0d_access", i), en_rise - r0,   vecs[i].e_rise);
         check($sformatf("vec%0d_en_off", i), mem_en, 1'b0);
         if (vecs[i].e_rise != 0) begin
            check($sformatf("vec%0d_we", i),   last_we,   vecs[i].e_we);
            check($sformatf("vec%0d_addr", i), last_addr, vecs[i].addr);
            if (vecs[i].e_we) check($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].wdata);
         end
      end

      // Timeout: enable held for exactly TIMEOUT cycles
      e0 = en_hi;
      do_req(CMD_READ, 8'h11, 16'h0000, 0, 1'b1);
      check("to_en_cycles", en_hi - e0, TIMEOUT);
      check("to_status", status, ST_ERROR);
      check("to_rdata",  rdata,  m_rdata);

      // Second request during WAIT is dropped and flagged
      check("ovr_pre", overrun, 1'b0);
      mem_lat = 12; mem_stall = 1'b0;
      tap_cmd = CMD_READ; tap_addr = 8'h77; tap_wdata = 16'h0000;
      tap_req_tgl = ~tap_req_tgl;
      wait_en("ovr_en_seen");
      tap_req_tgl = ~tap_req_tgl;
      wait_idle("ovr_done");
      repeat (SYNC_STAGES + 4) @(posedge clk);
      @(negedge clk);
      model_apply(CMD_READ, 8'h77, 16'h0000, 1'b0);
      m_over = 1'b1;
      check("ovr_flag",   overrun,   m_over);
      check("ovr_access", en_rise,   m_rise);
      check("ovr_ack",    ack_edges, m_ack);
      check("ovr_rdata",  rdata,     m_rdata);

      // Randomized requests against the model
      for (int i = 0; i < 40; i++) begin
         rc = 2'($urandom_range(0, 3));
         ra = 8'($urandom_range(0, 15));
         rd = 16'($urandom);
         rl = $urandom_range(0, 5);
         rs = ($urandom_range(0, 7) == 0);
         do_req(rc, ra, rd, rl, rs);
         check($sformatf("rnd%0d_status", i),  status,    m_status);
         check($sformatf("rnd%0d_rdata", i),   rdata,     m_rdata);
         check($sformatf("rnd%0d_ack", i),     ack_edges, m_ack);
         check($sformatf("rnd%0d_access", i),  en_rise,   m_rise);
         check($sformatf("rnd%0d_overrun", i), overrun,   m_over);
      end

      // Reset in the middle of a stalled WRITE
      mem_stall = 1'b1;
      tap_cmd = CMD_WRITE; tap_addr = 8'h40; tap_wdata = 16'hBEEF;
      tap_req_tgl = ~tap_req_tgl;
      wait_en("mid_en_seen");
      repeat (4) @(posedge clk);
      #1;
      a0 = ack_edges;
      sys_rst = 1'b1; tap_req_tgl = 1'b0;
      @(posedge clk);
      #1 sys_rst = 1'b0;
      check("mid_mem_en",  mem_en,  1'b0);
      check("mid_status",  status,  ST_OKAY);
      check("mid_ack_tgl", ack_tgl, 1'b0);
      check("mid_overrun", overrun, 1'b0);
      check("mid_rdata",   rdata,   16'h0000);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("mid_no_ack_edge", ack_edges - a0, 0);
      m_rise++;
      m_status = ST_OKAY; m_rdata = 16'h0000; m_over = 1'b0;

      do_req(CMD_WRITE, 8'h40, 16'hBEEF, 1, 1'b0);
      check("post_wr_status", status,    m_status);
      check("post_wr_ack",    ack_edges, m_ack + a0 - (m_ack - 1));
      do_req(CMD_READ, 8'h40, 16'h0000, 0, 1'b0);
      check("post_rd_rdata",  rdata,     16'hBEEF);
      check("post_rd_status", status,    ST_OKAY);
      check("post_access",    en_rise,   m_rise);

      check("port_stable", stab_err, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
